weights_clauses_fetch: RTL and testbench
========================================

# weights_clauses_fetch

Read-side sequencer for the weight and clause SRAMs. On a start command it streams a programmed number of clause words, then weight words, out of each SRAM's Port-B. Each 256-bit word is delivered to the accelerator core over a valid/ready stream tagged with its source. It is the consumer-side counterpart of the APB write glue that loads both SRAMs through Port-A.

## Interface
Parameters:
- ADDR_WIDTH, 11, SRAM local address width; also the width of the word counts
- DATA_WIDTH, 256, SRAM word / stream width

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  start pulse, sampled only in IDLE
- i_abort  in  1  abort current transfer
- i_num_clauses  in  ADDR_WIDTH  clause words to fetch (N), latched at start
- i_num_weights  in  ADDR_WIDTH  weight words to fetch (M), latched at start
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  one-cycle pulse on normal completion
- o_cmd_error  out  1  one-cycle pulse on an illegal start
- o_clauses_sram_enb  out  1  clause SRAM Port-B read enable
- o_clauses_sram_addrb  out  ADDR_WIDTH  clause SRAM Port-B address
- i_clauses_sram_doutb  in  DATA_WIDTH  clause SRAM Port-B data, valid 1 cycle after enb
- o_weight_sram_enb  out  1  weight SRAM Port-B read enable
- o_weight_sram_addrb  out  ADDR_WIDTH  weight SRAM Port-B address
- i_weight_sram_doutb  in  DATA_WIDTH  weight SRAM Port-B data, valid 1 cycle after enb
- o_data  out  DATA_WIDTH  stream data
- o_data_valid  out  1  stream valid
- o_data_is_weight  out  1  1 = weight word, 0 = clause word
- o_data_last  out  1  marks the final word of the transfer
- i_data_ready  in  1  stream ready

## Operation
FSM states are IDLE, CLAUSE, WEIGHT and DRAIN.

- **IDLE**
  - On i_start with N+M≠0: latch N and M, clear the address counter.
  - Next state is CLAUSE if N≠0, otherwise WEIGHT.
  - On i_start with N=M=0: pulse o_cmd_error and stay in IDLE.
- **CLAUSE**
  - Each issue cycle drives o_clauses_sram_enb=1 and addrb=counter, then increments the counter.
  - After issuing address N-1: clear the counter and go to WEIGHT if M≠0, otherwise to DRAIN.
- **WEIGHT**
  - Same as CLAUSE, on the weight SRAM, for addresses 0..M-1.
  - After issuing address M-1: go to DRAIN.
- **DRAIN**
  - Issue nothing.
  - Go to IDLE once the FIFO is empty and no read is in flight; o_done pulses in that IDLE cycle.
- **Output buffering**
  - 2-entry FIFO holding {data, is_weight, last}.
  - A read issues in a cycle only if (occupancy + in_flight − pop) < 2, where pop = o_data_valid & i_data_ready. No SRAM word is ever dropped.
  - The in-flight read's doutb is written into the FIFO on the following cycle. Its tag and last bit are registered at issue time.
  - last=1 only for the final issued read: weight M-1, or clause N-1 when M=0.
- **Stream**: o_data, o_data_is_weight and o_data_last come from the FIFO head. o_data_valid = FIFO not empty.
- **Start while busy**: o_cmd_error pulses for one cycle; the transfer is unaffected and the counts are not relatched.
- **i_abort in any non-IDLE state**
  - Next cycle: IDLE, FIFO flushed, in-flight read discarded, o_data_valid=0.
  - No o_done pulse.
  - i_abort has priority over a same-cycle issue or pop.
  - i_abort in IDLE has no effect.
- **Start and abort in the same IDLE cycle**: the abort is ignored and the start proceeds.
- enb is never asserted on both SRAMs in the same cycle. Address counters never exceed the count − 1.
- **Reset**: state IDLE, FIFO empty, counters 0; every output 0.

## Timing
- The start is sampled at cycle T. The first enb/addr 0 appears at T+1, FIFO write at T+2, first o_data_valid at T+3.
- With i_data_ready held high: one word per cycle. Words appear at T+3 … T+2+N+M, and o_done pulses at T+3+N+M.
- SRAM read latency is fixed at 1 cycle, and the block relies on it.
- Under back-pressure, o_data and its tags hold stable while valid=1 and ready=0.
- Reset asserted mid-transfer clears everything immediately (asynchronously). After release, the block waits in IDLE for a new start.

## Test plan
- **Basic transfer**: N=3, M=2, ready=1, start at T → clause addrb 0,1,2 at T+1..T+3, weight addrb 0,1 at T+4..T+5.
  - 5 words valid at T+3..T+7 with is_weight 0,0,0,1,1.
  - last only at T+7; o_done at T+8.
- **Back-pressure**: N=4, M=4, ready toggled pseudo-randomly → all 8 words delivered in order with no duplicates.
  - FIFO occupancy ≤2 and in-flight ≤1 at all times.
  - Data stable while stalled.
- **Degenerate counts**:
  - N=0, M=1 → a single weight word with last=1, clause enb never asserted.
  - N=0, M=0 → o_cmd_error pulse, o_busy stays 0.
- **Start while busy**: re-start during WEIGHT with different counts → o_cmd_error pulse; the original N+M words complete and o_done fires once.
- **Abort mid-transfer**: i_abort mid-WEIGHT with the FIFO full → next cycle IDLE, valid=0, no o_done.
  - A new start (N=1, M=1) then delivers clause 0 and weight 0 correctly.
- **Reset mid-transfer**: i_rst_n low while busy → all outputs 0 immediately.
  - After release, a clean transfer (N=2, M=0) completes with last on the second word.

Source files
------------

// File: rtl/weights_clauses_fetch.sv
// Port-B read sequencer: streams N clause words then M weight words from the two SRAMs
// into a 2-entry output FIFO that feeds a valid/ready stream tagged with source and last.
//   state  | meaning
//   IDLE   | waiting for start
//   CLAUSE | issuing clause SRAM reads 0..N-1
//   WEIGHT | issuing weight SRAM reads 0..M-1
//   DRAIN  | no more issues; waiting for FIFO and in-flight read to empty
module weights_clauses_fetch #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_num_clauses,
  input  logic [ADDR_WIDTH-1:0] i_num_weights,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_cmd_error,
  output logic                  o_clauses_sram_enb,
  output logic [ADDR_WIDTH-1:0] o_clauses_sram_addrb,
  input  logic [DATA_WIDTH-1:0] i_clauses_sram_doutb,
  output logic                  o_weight_sram_enb,
  output logic [ADDR_WIDTH-1:0] o_weight_sram_addrb,
  input  logic [DATA_WIDTH-1:0] i_weight_sram_doutb,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_data_is_weight,
  output logic                  o_data_last,
  input  logic                  i_data_ready
);

  typedef enum logic [1:0] {IDLE, CLAUSE, WEIGHT, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0]   n_lat, m_lat;
  logic                    latch;
  logic                    infl_valid, infl_is_w, infl_last;
  logic [DATA_WIDTH-1:0]   fifo_data [2];
  logic [1:0]              fifo_w, fifo_last;
  logic                    wr_ptr, rd_ptr;
  logic [1:0]              occ;
  logic                    pop, flush;
  logic                    issue, issue_w, issue_last;
  logic                    done_nxt, err_nxt;
  logic [2:0]              pending;
  logic                    room_ok;
  logic                    clause_end, weight_end;

  assign pop        = o_data_valid & i_data_ready;
  assign flush      = i_abort & (state != IDLE);
  // Entries that will still be occupied next cycle before any new issue lands
  assign pending    = {1'b0, occ} + {2'b0, infl_valid} - {2'b0, pop};
  assign room_ok    = pending < 3'd2;
  assign clause_end = (cnt == n_lat - ONE);
  assign weight_end = (cnt == m_lat - ONE);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    latch      = 1'b0;
    issue      = 1'b0;
    issue_w    = 1'b0;
    issue_last = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          if ((i_num_clauses == '0) && (i_num_weights == '0)) begin
            err_nxt = 1'b1;
          end else begin
            latch     = 1'b1;
            cnt_nxt   = '0;
            state_nxt = (i_num_clauses != '0) ? CLAUSE : WEIGHT;
          end
        end
      end
      CLAUSE: begin
        if (room_ok) begin
          issue      = 1'b1;
          issue_last = clause_end && (m_lat == '0);
          if (clause_end) begin
            cnt_nxt   = '0;
            state_nxt = (m_lat != '0) ? WEIGHT : DRAIN;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
      end
      WEIGHT: begin
        if (room_ok) begin
          issue      = 1'b1;
          issue_w    = 1'b1;
          issue_last = weight_end;
          if (weight_end) begin
            cnt_nxt   = '0;
            state_nxt = DRAIN;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
      end
      DRAIN: begin
        if (pending == 3'd0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE) begin
      if (i_start) err_nxt = 1'b1;
      // Abort wins over any issue, pop or completion in the same cycle
      if (i_abort) begin
        state_nxt  = IDLE;
        cnt_nxt    = '0;
        issue      = 1'b0;
        issue_last = 1'b0;
        done_nxt   = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      n_lat       <= '0;
      m_lat       <= '0;
      o_done      <= 1'b0;
      o_cmd_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      o_done      <= done_nxt;
      o_cmd_error <= err_nxt;
      if (latch) begin
        n_lat <= i_num_clauses;
        m_lat <= i_num_weights;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      infl_valid <= 1'b0;
      infl_is_w  <= 1'b0;
      infl_last  <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      occ        <= 2'd0;
      fifo_w     <= 2'b00;
      fifo_last  <= 2'b00;
      for (int i = 0; i < 2; i++) fifo_data[i] <= '0;
    end else if (flush) begin
      infl_valid <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      occ        <= 2'd0;
    end else begin
      infl_valid <= issue;
      infl_is_w  <= issue_w;
      infl_last  <= issue_last;
      if (infl_valid) begin
        fifo_data[wr_ptr] <= infl_is_w ? i_weight_sram_doutb : i_clauses_sram_doutb;
        fifo_w[wr_ptr]    <= infl_is_w;
        fifo_last[wr_ptr] <= infl_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= pending[1:0];
    end
  end

  assign o_busy               = (state != IDLE);
  assign o_clauses_sram_enb   = issue && (state == CLAUSE);
  assign o_clauses_sram_addrb = (state == CLAUSE) ? cnt : '0;
  assign o_weight_sram_enb    = issue && (state == WEIGHT);
  assign o_weight_sram_addrb  = (state == WEIGHT) ? cnt : '0;
  assign o_data_valid         = (occ != 2'd0);
  assign o_data               = fifo_data[rd_ptr];
  assign o_data_is_weight     = fifo_w[rd_ptr];
  assign o_data_last          = fifo_last[rd_ptr];

endmodule

// File: tb/tb_weights_clauses_fetch.sv
// Bench for weights_clauses_fetch: SRAM models, scoreboard of expected words per start,
// a negedge monitor that pops and compares, and directed plus randomized transfers.
module tb_weights_clauses_fetch;
  localparam int AW = 11;
  localparam int DW = 256;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, ready;
  logic [AW-1:0] num_c, num_w;
  logic          o_busy, o_done, o_cmd_error;
  logic          cl_enb, w_enb;
  logic [AW-1:0] cl_addr, w_addr;
  logic [DW-1:0] cl_dout, w_dout;
  logic [DW-1:0] o_data;
  logic          o_valid, o_is_w, o_last;

  always #5 clk = ~clk;

  weights_clauses_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_num_clauses(num_c), .i_num_weights(num_w),
    .o_busy(o_busy), .o_done(o_done), .o_cmd_error(o_cmd_error),
    .o_clauses_sram_enb(cl_enb), .o_clauses_sram_addrb(cl_addr), .i_clauses_sram_doutb(cl_dout),
    .o_weight_sram_enb(w_enb), .o_weight_sram_addrb(w_addr), .i_weight_sram_doutb(w_dout),
    .o_data(o_data), .o_data_valid(o_valid), .o_data_is_weight(o_is_w), .o_data_last(o_last),
    .i_data_ready(ready)
  );

  typedef struct {
    logic [DW-1:0] d;
    bit            w;
    bit            last;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0, bad = 0;
  int          done_seen = 0, err_seen = 0, exp_done = 0, exp_err = 0;
  int          cl_enb_seen = 0, issued = 0, popped = 0;
  int          cur_n = 0, cur_m = 0;
  int          ready_mode = 0;
  int unsigned seed = 1;

  // SRAM contents are a function of the per-transfer seed, the source and the address
  function automatic logic [DW-1:0] pat(input bit w, input logic [AW-1:0] a);
    logic [DW-1:0] r;
    for (int k = 0; k < 8; k++)
      r[k*32 +: 32] = seed ^ ({21'd0, a} * 32'h9E37_79B1) ^ (w ? 32'hA5A5_0000 : 32'h0) ^ k;
    return r;
  endfunction

  always @(posedge clk) begin
    if (cl_enb) cl_dout <= pat(1'b0, cl_addr);
    if (w_enb)  w_dout  <= pat(1'b1, w_addr);
  end

  task automatic check(input string nm, input logic [259:0] act, input logic [259:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  logic          prev_stall = 1'b0;
  logic [DW+1:0] prev_word;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      exp_t e;
      if (o_done)      done_seen++;
      if (o_cmd_error) err_seen++;
      if (cl_enb)      cl_enb_seen++;
      if (o_valid && ready && !abort) popped++;
      if (cl_enb || w_enb) begin
        issued++;
        check("enb_exclusive", cl_enb & w_enb, 0);
        check("outstanding_le2", (issued - popped) <= 2, 1);
        if (cl_enb) check("clause_addr_bound", int'(cl_addr) < cur_n, 1);
        if (w_enb)  check("weight_addr_bound", int'(w_addr) < cur_m, 1);
      end
      if (prev_stall)
        check("stall_hold", {o_valid, o_data, o_is_w, o_last}, {1'b1, prev_word});
      prev_stall = o_valid && !ready && !abort;
      prev_word  = {o_data, o_is_w, o_last};
      if (o_valid && ready && !abort) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stream_extra: got word %0h with no expected word pending", o_data);
        end else begin
          e = exp_q.pop_front();
          check("stream_word", {o_data, o_is_w, o_last}, {e.d, e.w, e.last});
        end
      end
    end
  end

  task automatic go(input int n, input int m);
    exp_t e;
    @(posedge clk);
    #1;
    seed   = $urandom;
    cur_n  = n;
    cur_m  = m;
    issued = 0;
    popped = 0;
    for (int i = 0; i < n; i++) begin
      e.d = pat(1'b0, AW'(i)); e.w = 1'b0; e.last = (m == 0) && (i == n - 1);
      exp_q.push_back(e);
    end
    for (int i = 0; i < m; i++) begin
      e.d = pat(1'b1, AW'(i)); e.w = 1'b1; e.last = (i == m - 1);
      exp_q.push_back(e);
    end
    if (n + m == 0) exp_err++;
    else            exp_done++;
    num_c = AW'(n);
    num_w = AW'(m);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    int k = 0;
    while (done_seen < exp_done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check({nm, "_done_count"}, done_seen, exp_done);
    check({nm, "_words_left"}, exp_q.size(), 0);
    check({nm, "_err_count"}, err_seen, exp_err);
  endtask

  task automatic wait_weight(input string nm);
    int k = 0;
    while (!w_enb && k < 500) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_reach_weight"}, w_enb, 1);
  endtask

  logic [6:0] basic_vec  [8] = '{7'b1100000, 7'b1100000, 7'b1101000, 7'b1011000,
                                 7'b1011000, 7'b1001001, 7'b1001011, 7'b0000100};
  int         basic_addr [8] = '{0, 1, 2, 0, 1, 0, 0, 0};

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_c = '0; num_w = '0;
    #23;
    check("reset_outputs", {o_busy, o_done, o_cmd_error, cl_enb, w_enb, o_valid, o_is_w, o_last,
                            |o_data, |cl_addr, |w_addr}, 0);
    #4 rst_n = 1'b1;

    // basic timeline N=3, M=2
    go(3, 2);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("basic_ctrl_c%0d", c + 1),
            {o_busy, cl_enb, w_enb, o_valid, o_done, o_valid & o_last, o_valid & o_is_w},
            basic_vec[c]);
      check($sformatf("basic_addr_c%0d", c + 1),
            cl_enb ? int'(cl_addr) : (w_enb ? int'(w_addr) : 0), basic_addr[c]);
    end
    wait_end("basic");

    ready_mode = 1;
    go(4, 4);
    wait_end("backpressure");

    ready_mode = 0;
    cl_enb_seen = 0;
    go(0, 1);
    wait_end("single_weight");
    check("single_weight_no_clause_enb", cl_enb_seen, 0);

    go(0, 0);
    @(negedge clk);
    check("zero_start", {o_busy, o_cmd_error}, 2'b01);
    repeat (3) begin
      @(negedge clk);
      check("zero_start_idle", o_busy, 0);
    end
    wait_end("zero");

    ready_mode = 1;
    go(3, 5);
    wait_weight("busy");
    @(posedge clk);
    #1;
    num_c = 7; num_w = 9; start = 1'b1;
    exp_err++;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_end("busy_start");

    ready_mode = 0;
    go(3, 6);
    wait_weight("abort");
    ready_mode = 2;
    repeat (4) @(posedge clk);
    #1;
    check("abort_fifo_full_valid", o_valid, 1);
    abort = 1'b1;
    exp_q.delete();
    exp_done--;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_next_idle", {o_busy, o_valid, o_done}, 0);
    repeat (5) @(negedge clk);
    check("abort_no_done", done_seen, exp_done);
    ready_mode = 0;
    go(1, 1);
    wait_end("after_abort");

    ready_mode = 1;
    for (int t = 0; t < 6; t++) begin
      int n, m;
      n = $urandom_range(0, 6);
      m = $urandom_range(0, 6);
      if (n + m == 0) m = 1;
      go(n, m);
      wait_end($sformatf("random%0d", t));
    end

    go(5, 5);
    repeat (6) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {o_busy, o_done, o_cmd_error, cl_enb, w_enb, o_valid, o_is_w, o_last,
                               |o_data, |cl_addr, |w_addr}, 0);
    exp_q.delete();
    exp_done--;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    ready_mode = 0;
    go(2, 0);
    wait_end("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
